// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS sweep controller: default widths,
// minimum dwell length and the sweep FSM state encoding.
package dds_ctrl_pkg;

    localparam int DDS_FW    = 32;   // frequency word width
    localparam int DDS_PW    = 12;   // phase word width
    localparam int DDS_DW    = 16;   // dwell counter width
    localparam int MIN_DWELL = 1;    // a dwell of 0 is stretched to this

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Per-point dwell timer. A load sets the count to max(load value, 1);
// while enabled it counts down and flags expiry in the last cycle of a point.
module dds_dwell_timer
    import dds_ctrl_pkg::*;
#(
    parameter int DW = DDS_DW
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] load_val_i,
    input  logic          en_i,
    output logic          expire_o
);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // Next count: load wins (zero coerced to minimum), else count down to the floor
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (load_val_i == '0) ? DW'(MIN_DWELL) : load_val_i;
        end else if (en_i && (cnt_q > DW'(MIN_DWELL))) begin
            cnt_d = cnt_q - DW'(1);
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry marks the final cycle of the current point
    assign expire_o = en_i && (cnt_q <= DW'(MIN_DWELL));

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep controller feeding the DDS Fword/Pword inputs.
// Configuration is shadowed on start; the step adder and stop compare
// live here, the per-point dwell timing lives in dds_dwell_timer.
module dds_sweep_ctrl
    import dds_ctrl_pkg::*;
#(
    parameter int FW = DDS_FW,
    parameter int PW = DDS_PW,
    parameter int DW = DDS_DW
) (
    input  logic          sys_clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          mode,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic [DW-1:0] dwell,
    input  logic [PW-1:0] p_offset,
    output logic [FW-1:0] Fword,
    output logic [PW-1:0] Pword,
    output logic          busy,
    output logic          step_strobe,
    output logic          done
);

    sweep_state_e  state_q, state_d;
    logic [FW-1:0] fword_q, fword_d;
    logic [PW-1:0] pword_q, pword_d;
    logic [FW-1:0] fstart_q, fstart_d;
    logic [FW-1:0] fstop_q, fstop_d;
    logic [FW-1:0] fstep_q, fstep_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d;
    logic          step_q, step_d;
    logic          done_q, done_d;

    logic          timer_load;
    logic [DW-1:0] timer_val;
    logic          timer_en;
    logic          timer_exp;
    logic [FW:0]   next_sum;
    logic          advance;

    dds_dwell_timer #(
        .DW(DW)
    ) u_timer (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .en_i      (timer_en),
        .expire_o  (timer_exp)
    );

    // Step adder with carry; advance only if the next point stays in range
    always_comb begin
        next_sum = {1'b0, fword_q} + {1'b0, fstep_q};
        advance  = !next_sum[FW] && (next_sum[FW-1:0] <= fstop_q) && (fstep_q != '0);
    end

    // Next-state and registered-output logic of the sweep FSM
    always_comb begin
        state_d    = state_q;
        fword_d    = fword_q;
        pword_d    = pword_q;
        fstart_d   = fstart_q;
        fstop_d    = fstop_q;
        fstep_d    = fstep_q;
        dwell_d    = dwell_q;
        mode_d     = mode_q;
        busy_d     = busy_q;
        step_d     = 1'b0;
        done_d     = 1'b0;
        timer_load = 1'b0;
        timer_val  = dwell_q;
        timer_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    fstart_d   = f_start;
                    fstop_d    = f_stop;
                    fstep_d    = f_step;
                    dwell_d    = dwell;
                    mode_d     = mode;
                    fword_d    = f_start;
                    pword_d    = p_offset;
                    busy_d     = 1'b1;
                    step_d     = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = dwell;
                    state_d    = DWELL;
                end
            end
            DWELL: begin
                if (abort) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_en = 1'b1;
                    if (timer_exp) begin
                        if (advance) begin
                            fword_d    = next_sum[FW-1:0];
                            step_d     = 1'b1;
                            timer_load = 1'b1;
                        end else if (mode_q) begin
                            fword_d    = fstart_q;
                            step_d     = 1'b1;
                            timer_load = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, shadow configuration and output registers
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            fword_q  <= '0;
            pword_q  <= '0;
            fstart_q <= '0;
            fstop_q  <= '0;
            fstep_q  <= '0;
            dwell_q  <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            step_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fword_q  <= fword_d;
            pword_q  <= pword_d;
            fstart_q <= fstart_d;
            fstop_q  <= fstop_d;
            fstep_q  <= fstep_d;
            dwell_q  <= dwell_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            step_q   <= step_d;
            done_q   <= done_d;
        end
    end

    assign Fword       = fword_q;
    assign Pword       = pword_q;
    assign busy        = busy_q;
    assign step_strobe = step_q;
    assign done        = done_q;

endmodule
